// File: rtl/load_store_unit.sv
// Data-memory initiator: lane alignment, split/merge of word-crossing accesses, load extension.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses skip memory and report resp_err.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            AddressingControl,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ACC0, S_CAP0, S_ACC1, S_CAP1, S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic                    we_q;
  logic [2:0]              mode_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, buf0_q, buf1_q, buf0_d, buf1_d;

  logic                    take;
  logic                    we_e;
  logic [2:0]              mode_e;
  logic [ADDR_WIDTH-1:0]   addr_e;
  logic [DATA_WIDTH-1:0]   wdata_e;

  logic [1:0]              off;
  logic [BE_W-1:0]         mask;
  logic [2:0]              size_n;
  logic                    split;
  logic [ADDR_WIDTH-1:0]   a0, a1;
  logic [BE_W-1:0]         be0, be1;
  logic [DATA_WIDTH-1:0]   wd0, wd1;
  logic [5:0]              sh1;

  logic                    err_d;
  logic                    req_ready_d, resp_valid_d, mem_en_d, mem_we_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_d, mem_wdata_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_d;
  logic [BE_W-1:0]         mem_be_d;
  logic [2*DATA_WIDTH-1:0] raw;
  logic                    sx;

  // Effective request: live inputs on the transfer cycle, captured copy afterwards
  assign take    = (state_q == S_IDLE) & req_valid;
  assign we_e    = take ? req_we            : we_q;
  assign mode_e  = take ? AddressingControl : mode_q;
  assign addr_e  = take ? req_addr          : addr_q;
  assign wdata_e = take ? req_wdata         : wdata_q;

  always_comb begin
    mask   = BE_W'(4'b1111);
    size_n = 3'd4;
    case (mode_e[1:0])
      2'b00:   begin mask = BE_W'(4'b0001); size_n = 3'd1; end
      2'b01:   begin mask = BE_W'(4'b0011); size_n = 3'd2; end
      default: begin mask = BE_W'(4'b1111); size_n = 3'd4; end
    endcase
  end

  assign off   = addr_e[1:0];
  assign split = ({1'b0, off} + size_n) > 3'd4;
  assign a0    = {addr_e[ADDR_WIDTH-1:2], 2'b00};
  assign a1    = a0 + ADDR_WIDTH'(4);
  assign be0   = BE_W'({{BE_W{1'b0}}, mask} << off);
  assign be1   = BE_W'({{BE_W{1'b0}}, mask} >> (3'd4 - {1'b0, off}));
  assign wd0   = wdata_e << {off, 3'b000};
  // A shift of 32 (off = 0) yields zero, so the second-word lanes stay clear when unsplit
  assign sh1   = {3'd4 - {1'b0, off}, 3'b000};
  assign wd1   = wdata_e >> sh1;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = (off & mask[2:1]) != 2'b00;
`endif

  // Next state, read buffers and next registered outputs
  always_comb begin
    state_d = state_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    err_d   = 1'b0;
    if (take) begin
      buf0_d = '0;
      buf1_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (mode_e[1:0] == 2'b11) begin
            state_d = S_RESP;
`ifdef LSU_MISALIGN_TRAP_EN
          end else if (misalign) begin
            state_d = S_RESP;
            err_d   = 1'b1;
`endif
          end else begin
            state_d = S_ACC0;
          end
        end
      end
      S_ACC0: begin
        if (mem_ready) begin
          if (!we_e)      state_d = S_CAP0;
          else if (split) state_d = S_ACC1;
          else            state_d = S_RESP;
        end
      end
      S_CAP0: begin
        buf0_d  = mem_rdata;
        state_d = split ? S_ACC1 : S_RESP;
      end
      S_ACC1: begin
        if (mem_ready) state_d = we_e ? S_RESP : S_CAP1;
      end
      S_CAP1: begin
        buf1_d  = mem_rdata;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    mem_en_d     = (state_d == S_ACC0) || (state_d == S_ACC1);
    mem_we_d     = mem_en_d & we_e;
    mem_addr_d   = '0;
    mem_be_d     = '0;
    mem_wdata_d  = '0;
    if (state_d == S_ACC0) begin
      mem_addr_d  = a0;
      mem_be_d    = be0;
      mem_wdata_d = wd0;
    end else if (state_d == S_ACC1) begin
      mem_addr_d  = a1;
      mem_be_d    = be1;
      mem_wdata_d = wd1;
    end

    raw          = {buf1_d, buf0_d} >> {off, 3'b000};
    sx           = ~mode_e[2];
    resp_rdata_d = '0;
    if (resp_valid_d && !we_e && !err_d) begin
      case (mode_e[1:0])
        2'b00:   resp_rdata_d = {{(DATA_WIDTH-8){sx & raw[7]}}, raw[7:0]};
        2'b01:   resp_rdata_d = {{(DATA_WIDTH-16){sx & raw[15]}}, raw[15:0]};
        2'b10:   resp_rdata_d = raw[DATA_WIDTH-1:0];
        default: resp_rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      mode_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_e;
      mode_q     <= mode_e;
      addr_q     <= addr_e;
      wdata_q    <= wdata_e;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_be     <= mem_be_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) resp_err <= 1'b0;
    else     resp_err <= err_d;
  end
`else
  assign resp_err = 1'b0;
`endif

endmodule
